// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, field widths
// and the per-source eligibility rule used by the top level.
package irq_ctrl_pkg;

  localparam logic [7:0] OffEnable    = 8'h00;
  localparam logic [7:0] OffMode      = 8'h04;
  localparam logic [7:0] OffPending   = 8'h08;
  localparam logic [7:0] OffInService = 8'h0C;
  localparam logic [7:0] OffThreshold = 8'h10;
  localparam logic [7:0] OffEoi       = 8'h14;
  localparam logic [7:0] OffPrioBase  = 8'h40;

  localparam int unsigned MaxIrq       = 32;
  localparam int unsigned PrioWDefault = 3;
  localparam int unsigned ApbDataW     = 32;

  // Priority 0 can never exceed a threshold of 0 or more, so it is never delivered.
  function automatic logic irq_eligible(logic pending, logic enable, logic in_service,
                                        int unsigned prio, int unsigned threshold);
    return pending & enable & ~in_service & (prio > threshold);
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational winner selection: highest priority among eligible sources,
// ties resolved towards the lowest index.
module irq_arbiter #(
  parameter int unsigned NUM_IRQ = 16,
  parameter int unsigned PRIO_W  = 3,
  localparam int unsigned ID_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0]             eligible_i,
  input  logic [NUM_IRQ-1:0][PRIO_W-1:0] prio_i,
  output logic                           win_valid_o,
  output logic [ID_W-1:0]                win_id_o,
  output logic [PRIO_W-1:0]              win_prio_o
);

  logic              best_valid;
  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;

  // Ascending scan with strict '>' keeps the lowest index on equal priority.
  always_comb begin
    best_valid = 1'b0;
    best_id    = '0;
    best_prio  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible_i[i] && (!best_valid || (prio_i[i] > best_prio))) begin
        best_valid = 1'b1;
        best_id    = ID_W'(i);
        best_prio  = prio_i[i];
      end
    end
  end

  assign win_valid_o = best_valid;
  assign win_id_o    = best_id;
  assign win_prio_o  = best_prio;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level capture, priority arbitration against a
// threshold, sticky valid/ready claim with end-of-interrupt, APB configuration.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 16,
  parameter int unsigned PRIO_W     = PrioWDefault,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = ApbDataW,
  localparam int unsigned ID_W      = $clog2(NUM_IRQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_IRQ-1:0]    irq_in,
  output logic                  irq_valid,
  output logic [ID_W-1:0]       irq_id,
  input  logic                  irq_ready,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  logic [NUM_IRQ-1:0]             enable_q, enable_d, mode_q, mode_d;
  logic [NUM_IRQ-1:0]             pending_q, pending_d, in_service_q, in_service_d;
  logic [NUM_IRQ-1:0]             irq_prev_q, irq_prev_d;
  logic [PRIO_W-1:0]              threshold_q, threshold_d;
  logic [NUM_IRQ-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic                           irq_valid_q, irq_valid_d;
  logic [ID_W-1:0]                irq_id_q, irq_id_d;

  logic [7:0]            addr, prio_off;
  logic [5:0]            prio_idx;
  logic                  access, mapped, prio_hit, wr_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic [NUM_IRQ-1:0]    w1c_mask, set_ev, clr_mask, eligible;
  logic                  eoi_hit, claim;
  logic [ID_W-1:0]       eoi_id;
  logic                  win_valid;
  logic [ID_W-1:0]       win_id;
  logic [PRIO_W-1:0]     win_prio;
  logic                  unused_bits;

  // Only the low byte of the address selects a register.
  assign addr     = paddr[7:0];
  assign access   = psel & penable;
  assign prio_off = addr - OffPrioBase;
  assign prio_idx = prio_off[7:2];
  assign prio_hit = (addr >= OffPrioBase) && (prio_off[1:0] == 2'b00) &&
                    (32'(prio_idx) < NUM_IRQ);

  always_comb begin
    mapped = 1'b1;
    rdata  = '0;
    case (addr)
      OffEnable:    rdata = DATA_WIDTH'(enable_q);
      OffMode:      rdata = DATA_WIDTH'(mode_q);
      OffPending:   rdata = DATA_WIDTH'(pending_q);
      OffInService: rdata = DATA_WIDTH'(in_service_q);
      OffThreshold: rdata = DATA_WIDTH'(threshold_q);
      OffEoi:       rdata = '0;
      default: begin
        mapped = prio_hit;
        if (prio_hit) rdata = DATA_WIDTH'(prio_q[prio_idx[ID_W-1:0]]);
      end
    endcase
  end

  assign wr_en   = access & pwrite & mapped;
  assign prdata  = (access && mapped) ? rdata : '0;
  assign pslverr = access & ~mapped;
  assign pready  = 1'b1;

  always_comb begin
    enable_d    = enable_q;
    mode_d      = mode_q;
    threshold_d = threshold_q;
    prio_d      = prio_q;
    w1c_mask    = '0;
    eoi_hit     = 1'b0;
    if (wr_en) begin
      case (addr)
        OffEnable:    enable_d    = pwdata[NUM_IRQ-1:0];
        OffMode:      mode_d      = pwdata[NUM_IRQ-1:0];
        OffPending:   w1c_mask    = pwdata[NUM_IRQ-1:0];
        OffThreshold: threshold_d = pwdata[PRIO_W-1:0];
        OffEoi:       eoi_hit     = (pwdata < DATA_WIDTH'(NUM_IRQ));
        OffInService: ;
        default:      prio_d[prio_idx[ID_W-1:0]] = pwdata[PRIO_W-1:0];
      endcase
    end
  end

  assign eoi_id = pwdata[ID_W-1:0];

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      eligible[i] = irq_eligible(pending_q[i], enable_q[i], in_service_q[i],
                                 32'(prio_q[i]), 32'(threshold_q));
    end
  end

  irq_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .PRIO_W  (PRIO_W)
  ) u_arbiter (
    .eligible_i  (eligible),
    .prio_i      (prio_q),
    .win_valid_o (win_valid),
    .win_id_o    (win_id),
    .win_prio_o  (win_prio)
  );

  assign claim  = irq_valid_q & irq_ready;
  assign set_ev = enable_q & ((mode_q & irq_in & ~irq_prev_q) | (~mode_q & irq_in));

  // A fresh set event beats any clear in the same cycle, so no edge is lost.
  always_comb begin
    clr_mask = w1c_mask;
    if (claim) clr_mask[irq_id_q] = 1'b1;
    pending_d  = (pending_q & ~clr_mask) | set_ev;
    irq_prev_d = irq_in;

    in_service_d = in_service_q;
    if (eoi_hit) in_service_d[eoi_id] = 1'b0;
    if (claim)   in_service_d[irq_id_q] = 1'b1;

    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    if (claim) begin
      irq_valid_d = 1'b0;
    end else if (irq_valid_q) begin
      // Presentation is sticky: keep the id, only withdraw if it lost eligibility.
      irq_valid_d = eligible[irq_id_q];
    end else if (win_valid) begin
      irq_valid_d = 1'b1;
      irq_id_d    = win_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q     <= '0;
      mode_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      irq_prev_q   <= '0;
      threshold_q  <= '0;
      prio_q       <= '0;
      irq_valid_q  <= 1'b0;
      irq_id_q     <= '0;
    end else begin
      enable_q     <= enable_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      irq_prev_q   <= irq_prev_d;
      threshold_q  <= threshold_d;
      prio_q       <= prio_d;
      irq_valid_q  <= irq_valid_d;
      irq_id_q     <= irq_id_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;

  assign unused_bits = ^{paddr, pwdata, win_prio};

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller for the CPU complex: latches up to NUM_IRQ external sources as edge- or level-triggered, arbitrates by programmable per-source priority against a global threshold, and presents the winner to the core over a valid/ready claim handshake with explicit end-of-interrupt. It generalises the fixed 16-source, 4-bit-ID interrupt path of the top level. Configuration is through an APB slave on the same clock.

## Interface
- NUM_IRQ, 16: number of sources, legal 2..32
- PRIO_W, 3: priority width; priority 0 = never delivered
- ADDR_WIDTH, 32: APB address width
- DATA_WIDTH, 32: APB data width, fixed 32
- ID_W, $clog2(NUM_IRQ): derived, not overridable
- clk  in  1  single clock for all logic and APB
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  NUM_IRQ  sources, synchronous to clk
- irq_valid  out  1  winning interrupt presented
- irq_id  out  ID_W  index of presented source
- irq_ready  in  1  core claims presented interrupt
- paddr  in  ADDR_WIDTH; psel, penable, pwrite  in  1; pwdata  in  32; prdata  out  32; pready  out  1; pslverr  out  1

## Operation
- Registers (byte offsets, paddr[7:0]): 0x00 ENABLE RW; 0x04 MODE RW (1=edge, 0=level); 0x08 PENDING R / W1C; 0x0C IN_SERVICE R; 0x10 THRESHOLD RW [PRIO_W-1:0]; 0x14 EOI W (write id), reads 0; 0x40+4*i PRIO[i] RW [PRIO_W-1:0]. Bits at/above NUM_IRQ read 0, writes ignored.
- Unmapped offset: pslverr=1 in access phase, prdata=0, no state change.
- Pending set: edge mode on irq_in[i] & ~irq_prev[i]; level mode while irq_in[i]=1. Set only if ENABLE[i].
- Eligible[i] = PENDING[i] & ENABLE[i] & ~IN_SERVICE[i] & (PRIO[i] > THRESHOLD).
- Arbitration: highest PRIO wins; tie -> lowest index.
- Claim (irq_valid & irq_ready): PENDING[id] cleared, IN_SERVICE[id] set.
- EOI write of id < NUM_IRQ clears IN_SERVICE[id]; id >= NUM_IRQ ignored, no error.
- Presentation is sticky: while irq_valid=1 and no claim, irq_id holds even if a higher-priority source becomes eligible. If the presented source stops being eligible (disabled, W1C, threshold raised), irq_valid drops next cycle.
- Simultaneous: new set event and W1C same bit -> set wins. Claim and EOI on same id -> claim wins. Claim and W1C on same id -> bit cleared, claim proceeds.

## Timing
- Reset: all registers 0, irq_prev 0, irq_valid=0, irq_id=0, prdata=0, pslverr=0; pready tied 1.
- APB zero wait states; write committed at the clock edge of access phase; prdata combinational in access phase.
- Latency: irq_in first high at edge k -> PENDING after k -> irq_valid/irq_id registered after k+1 (2 cycles).
- After a claim at edge c, irq_valid=0 after c; next winner may be presented after c+1.
- Reset mid-handshake: irq_valid drops immediately (async); all pending/in-service lost.

## Structure
- Package irq_ctrl_pkg: register offset localparams, THRESHOLD/PRIO field widths, eligibility helper function.
- Sub-module irq_arbiter: combinational priority/index tree (NUM_IRQ, PRIO_W) producing winner valid, id, prio; top instantiates one and registers output.

## Test plan
- Reset, write ENABLE=0x1, PRIO[0]=3, pulse irq_in[0] one cycle -> irq_valid=1, irq_id=0 two cycles after pulse; PENDING=0x1 before claim.
- Sources 2 and 5 both PRIO 4, edge together -> id 2 first; claim, EOI 2 -> id 5 presented.
- THRESHOLD=4, PRIO[3]=4 pending -> no irq_valid; THRESHOLD=3 -> irq_valid, irq_id=3 next cycle.
- Level source 7 held high, claimed -> not re-presented until EOI 7; after EOI re-presented within 2 cycles.
- W1C PENDING bit 1 same cycle as new edge on irq_in[1] -> PENDING[1] reads 1.
- Read offset 0x30 -> pslverr=1, prdata=0; EOI write of 31 with NUM_IRQ=16 -> IN_SERVICE unchanged.
